mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single physical memory port (pmem read/write path) between IFU (fetch, read-only) and LSU (load/store).
//  Accepts one request at a time via valid/ready, owns the downstream req/resp handshake, routes the response back to
//  the owner. Watchdog returns an error response if memory stalls. Sits between IFU/LSU and the pmem DPI bridge.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; wmask width = DATA_W/8
//  TMO_CYC  255  max cycles in REQ+WAIT before timeout error (1..2^16-1)
// PORTS
//  clk             in   1        clock, rising edge
//  rst_n           in   1        asynchronous active-low reset
//  ifu_req_valid   in   1        IFU read request
//  ifu_req_ready   out  1        IFU request accepted this cycle
//  ifu_addr        in   ADDR_W   IFU fetch address
//  ifu_resp_valid  out  1        one-cycle pulse: IFU response
//  ifu_rdata       out  DATA_W   fetched word
//  ifu_resp_err    out  1        qualifies ifu_resp_valid: timeout
//  lsu_req_valid   in   1        LSU request
//  lsu_req_ready   out  1        LSU request accepted this cycle
//  lsu_addr        in   ADDR_W   LSU address
//  lsu_wen         in   1        1=write, 0=read
//  lsu_wdata       in   DATA_W   write data
//  lsu_wmask       in   DATA_W/8 byte mask
//  lsu_resp_valid  out  1        one-cycle pulse: LSU response (read data or write ack)
//  lsu_rdata       out  DATA_W   read data (0 for writes)
//  lsu_resp_err    out  1        qualifies lsu_resp_valid: timeout
//  mem_req_valid   out  1        downstream request
//  mem_req_ready   in   1        downstream accepts request
//  mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
//  mem_resp_valid  in   1        downstream response
//  mem_rdata       in   DATA_W   downstream read data
//  busy            out  1        state != IDLE
//  owner           out  1        0=IFU, 1=LSU; holds last grant
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all outputs 0; latched request regs 0; watchdog 0; rr pointer=IFU.
//  FSM IDLE -> REQ -> WAIT -> RESP -> IDLE. One outstanding transaction; no pipelining.
//  IDLE: *_req_ready combinational, asserted only for the arbitration winner while its valid=1. Both ready never 1 together.
//   Fixed priority: LSU over IFU. On handshake latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0), set owner, go REQ.
//  REQ: mem_req_valid=1, fields stable. mem_req_ready=1 -> WAIT (same-cycle mem_resp_valid ignored; sampled in WAIT only).
//  WAIT: on mem_resp_valid, register mem_rdata (0 if write), err=0 -> RESP.
//  RESP: owner's resp_valid=1 for exactly one cycle, rdata/err valid that cycle only; no back-pressure. -> IDLE.
//   New request not accepted in RESP; earliest next accept is the following IDLE cycle (throughput: 1 per >=4 cycles).
//  Watchdog: counter 0 on entering REQ, +1 per cycle in REQ/WAIT; reaching TMO_CYC -> RESP with err=1, rdata=0;
//   mem_req_valid drops; later mem_resp_valid for aborted transaction is dropped (ignored outside WAIT).
//  Non-owner resp_valid always 0. rdata outputs hold last value outside RESP.
//  rst_n asserted mid-transaction: immediate return to IDLE, no response issued, in-flight request abandoned.
//  Requester valid dropped after acceptance has no effect. Request fields from requester sampled only at handshake.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. 1-bit pointer names preferred requester; on each grant pointer <- other requester.
//   Both valid in IDLE -> preferred one wins. Only one valid -> it wins regardless.
//  ARB_RR_EN undefined: fixed LSU priority as above; pointer logic absent.
// TESTING
//  IFU read 0x80000000, mem ready at once, resp after 2 cycles data 0x00100093 -> ifu_resp_valid 1 cycle, rdata 0x00100093, err 0, lsu_resp_valid 0.
//  LSU write 0x80001004 data 0xDEADBEEF mask 4'b0100 -> mem_addr/wdata/wmask/wen match while mem_req_valid; lsu_resp_valid 1 cycle, rdata 0.
//  IFU and LSU valid same cycle in IDLE -> fixed: LSU granted, IFU granted next IDLE; ARB_RR_EN: IFU first after reset, then LSU, alternating.
//  TMO_CYC=8, mem_req_ready held 1, mem_resp_valid never -> resp_valid with err=1, rdata 0 exactly 8 cycles after entering REQ; late mem_resp_valid ignored.
//  mem_req_ready low 5 cycles -> mem_req_valid/addr stable all 5 cycles; no response before acceptance.
//  rst_n low during WAIT -> busy=0, all outputs 0 immediately; no resp_valid after release; next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (IFU fetch / LSU load-store) arbiter onto a single memory port with a timeout watchdog.
// Define ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority over the IFU.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [15:0] WDOG_LAST = 16'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [15:0]       wdog;
  logic              timeout;
  logic              grant_lsu;
  logic              can_accept;
  logic              accept;
  logic              done;
  logic              err_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              err_q;

`ifdef ARB_RR_EN
  // rr_ptr names the preferred requester: 0=IFU, 1=LSU
  logic rr_ptr;
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant_lsu;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  // Gate with rst_n so no handshake can complete while reset is held.
  assign can_accept    = (state == IDLE) & rst_n;
  assign lsu_req_ready = can_accept & grant_lsu;
  assign ifu_req_ready = can_accept & ifu_req_valid & ~grant_lsu;
  assign accept        = lsu_req_ready | ifu_req_ready;
  assign timeout       = (wdog == WDOG_LAST);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        if (timeout) begin
          state_nxt = RESP;
          done      = 1'b1;
          err_nxt   = 1'b1;
        end else if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A real response wins over a timeout landing in the same cycle.
        if (mem_resp_valid) begin
          state_nxt = RESP;
          done      = 1'b1;
          rdata_nxt = mem_wen ? '0 : mem_rdata;
        end else if (timeout) begin
          state_nxt = RESP;
          done      = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wdog      <= '0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      err_q     <= 1'b0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        wdog <= '0;
      end else if (state == REQ || state == WAIT) begin
        wdog <= wdog + 16'd1;
      end
      if (accept) begin
        owner     <= grant_lsu;
        mem_addr  <= grant_lsu ? lsu_addr : ifu_addr;
        mem_wen   <= grant_lsu & lsu_wen;
        mem_wdata <= grant_lsu ? lsu_wdata : '0;
        mem_wmask <= grant_lsu ? lsu_wmask : {MASK_W{1'b0}};
      end
      if (done) begin
        err_q <= err_nxt;
        if (owner) lsu_rdata <= rdata_nxt;
        else       ifu_rdata <= rdata_nxt;
      end
    end
  end

  assign mem_req_valid  = (state == REQ);
  assign busy           = (state != IDLE);
  assign ifu_resp_valid = (state == RESP) & ~owner;
  assign lsu_resp_valid = (state == RESP) & owner;
  assign ifu_resp_err   = ifu_resp_valid & err_q;
  assign lsu_resp_err   = lsu_resp_valid & err_q;

endmodule
